// File: rtl/pixel_fetch_pipe_pkg.sv
// Shared types and constants for the pixel fetch stage.
//   - SRAM bus widths and default object base addresses
//   - ObjectID enumeration produced by the object decoder
//   - RGB565 -> RGB888 expansion and sprite-edge helpers
package pixel_fetch_pipe_pkg;

  localparam int SRAM_ADDR_WIDTH = 20;
  localparam int SRAM_DATA_WIDTH = 16;

  // Cycles from i_valid to o_rgb_valid (address stage + capture stage).
  localparam int FETCH_LATENCY = 2;

  localparam int MAP_H      = 640;
  localparam int MAP_V      = 480;
  localparam int IMAGE_SIZE = 32;

  typedef logic [SRAM_ADDR_WIDTH-1:0] sram_addr_t;
  typedef logic [SRAM_DATA_WIDTH-1:0] sram_data_t;

  // The map fills the bottom of SRAM, sprites are packed right after it.
  localparam sram_addr_t MAP_BASE_DEFAULT  = 20'd0;
  localparam sram_addr_t CAR1_BASE_DEFAULT = sram_addr_t'(MAP_H * MAP_V);
  localparam sram_addr_t CAR2_BASE_DEFAULT = CAR1_BASE_DEFAULT + sram_addr_t'(IMAGE_SIZE * IMAGE_SIZE);

  typedef enum logic [1:0] {
    OBJECT_MAP  = 2'd0,
    OBJECT_CAR1 = 2'd1,
    OBJECT_CAR2 = 2'd2
  } ObjectID;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb888_t;

  localparam rgb888_t RGB_BLACK = '{r: 8'h00, g: 8'h00, b: 8'h00};

  // Replicate the top bits into the low bits so full-scale 565 maps to 8'hFF.
  function automatic rgb888_t rgb565_expand(input sram_data_t d);
    rgb888_t c;
    c.r = {d[15:11], d[15:13]};
    c.g = {d[10:5],  d[10:9]};
    c.b = {d[4:0],   d[4:2]};
    return c;
  endfunction

  // True when a sprite-relative index lies on the outer ring of the sprite.
  function automatic logic is_sprite_edge(input sram_addr_t idx);
    sram_addr_t row_v;
    sram_addr_t col_v;
    row_v = idx / sram_addr_t'(IMAGE_SIZE);
    col_v = idx % sram_addr_t'(IMAGE_SIZE);
    return (row_v == 20'd0) || (row_v == sram_addr_t'(IMAGE_SIZE - 1)) ||
           (col_v == 20'd0) || (col_v == sram_addr_t'(IMAGE_SIZE - 1));
  endfunction

endpackage

// File: rtl/pixel_fetch_pipe_if.sv
// Write-request channel into the pixel fetch stage.
//   i_wr_req  : request, held by the requester until o_wr_ack
//   i_wr_addr : absolute SRAM word address
//   i_wr_data : RGB565 word
//   o_wr_ack  : one-cycle pulse when the write is committed
// master = requester (sprite/map loader), slave = pixel_fetch_pipe.
interface pixel_fetch_pipe_if;
  import pixel_fetch_pipe_pkg::*;

  logic       i_wr_req;
  sram_addr_t i_wr_addr;
  sram_data_t i_wr_data;
  logic       o_wr_ack;

  modport master (output i_wr_req, output i_wr_addr, output i_wr_data, input o_wr_ack);
  modport slave  (input i_wr_req, input i_wr_addr, input i_wr_data, output o_wr_ack);
endinterface

// File: rtl/pixel_fetch_pipe_sram_write_arbiter.sv
// sram_write_arbiter: write FSM and data-bus drive for the single-port SRAM.
// Writes are only started in vertical blanking with no active pixel, and take
// SETUP (OE off, bus driven) -> STROBE (WE low) -> HOLD (WE high, ack) cycles.
//   i_clk, i_rst       : clock, asynchronous active-high reset
//   i_vblank, i_valid  : blanking window and active-pixel flag
//   wr_bus             : write request channel (slave side)
//   o_busy             : FSM currently outside W_IDLE
//   o_claim            : FSM will own the address bus after this edge
//   o_claim_addr       : address to present while the FSM owns the bus
//   o_we_n, o_oe_n     : SRAM strobes (registered)
//   o_dq_oe, o_dq      : data-bus drive enable and value (registered)
module sram_write_arbiter
  import pixel_fetch_pipe_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_vblank,
  input  logic              i_valid,
  pixel_fetch_pipe_if.slave wr_bus,
  output logic              o_busy,
  output logic              o_claim,
  output sram_addr_t        o_claim_addr,
  output logic              o_we_n,
  output logic              o_oe_n,
  output logic              o_dq_oe,
  output sram_data_t        o_dq
);

  localparam logic [1:0] W_IDLE   = 2'd0;
  localparam logic [1:0] W_SETUP  = 2'd1;
  localparam logic [1:0] W_STROBE = 2'd2;
  localparam logic [1:0] W_HOLD   = 2'd3;

  logic [1:0] state_r;
  logic [1:0] state_next_s;
  logic       start_s;
  logic       we_n_r;
  logic       oe_n_r;
  logic       dq_oe_r;
  logic       ack_r;
  sram_addr_t addr_r;
  sram_data_t data_r;

  assign start_s = wr_bus.i_wr_req & i_vblank & ~i_valid;

  // Next-state logic of the write FSM.
  always_comb begin
    state_next_s = W_IDLE;
    case (state_r)
      W_IDLE: begin
        if (start_s) state_next_s = W_SETUP;
        else         state_next_s = W_IDLE;
      end
      W_SETUP: begin
        // Blanking ended before the strobe: abandon, requester retries later.
        if (i_vblank) state_next_s = W_STROBE;
        else          state_next_s = W_IDLE;
      end
      W_STROBE: state_next_s = W_HOLD;
      W_HOLD:   state_next_s = W_IDLE;
      default:  state_next_s = W_IDLE;
    endcase
  end

  // State, strobes, bus drive and ack registers.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_r <= W_IDLE;
      we_n_r  <= 1'b1;
      oe_n_r  <= 1'b0;
      dq_oe_r <= 1'b0;
      ack_r   <= 1'b0;
      addr_r  <= 20'd0;
      data_r  <= 16'd0;
    end else begin
      state_r <= state_next_s;
      we_n_r  <= 1'b1;
      ack_r   <= 1'b0;
      case (state_r)
        W_IDLE: begin
          if (start_s) begin
            oe_n_r  <= 1'b1;
            dq_oe_r <= 1'b1;
            addr_r  <= wr_bus.i_wr_addr;
            data_r  <= wr_bus.i_wr_data;
          end else begin
            oe_n_r  <= 1'b0;
            dq_oe_r <= 1'b0;
          end
        end
        W_SETUP: begin
          if (i_vblank) begin
            we_n_r <= 1'b0;
          end else begin
            oe_n_r  <= 1'b0;
            dq_oe_r <= 1'b0;
          end
        end
        W_STROBE: ack_r <= 1'b1;
        W_HOLD: begin
          oe_n_r  <= 1'b0;
          dq_oe_r <= 1'b0;
        end
        default: begin
          oe_n_r  <= 1'b0;
          dq_oe_r <= 1'b0;
        end
      endcase
    end
  end

  assign o_busy       = (state_r != W_IDLE);
  assign o_claim      = (state_next_s != W_IDLE);
  assign o_claim_addr = (state_r == W_IDLE) ? wr_bus.i_wr_addr : addr_r;
  assign o_we_n       = we_n_r;
  assign o_oe_n       = oe_n_r;
  assign o_dq_oe      = dq_oe_r;
  assign o_dq         = data_r;
  assign wr_bus.o_wr_ack = ack_r;

endmodule

// File: rtl/pixel_fetch_pipe.sv
// pixel_fetch_pipe: turns (object ID, pixel index) into an SRAM read and
// delivers 8-bit R/G/B two cycles later, with syncs delayed to match. Owns the
// SRAM bus; blanking-time writes are arbitrated by sram_write_arbiter.
//   i_clk, i_rst              : pixel clock, asynchronous active-high reset
//   i_valid, i_object_id,
//   i_pixel_index             : decoder output for the current pixel
//   i_hsync, i_vsync, i_vblank: undelayed VGA timing
//   wr_bus                    : write request channel (slave side)
//   o_SRAM_*, io_SRAM_DQ      : SRAM bus
//   o_VGA_R/G/B, o_VGA_HS/VS,
//   o_rgb_valid               : aligned colour and timing outputs
// Optional: define PIXEL_FETCH_BBOX_OVERLAY_EN to paint sprite borders magenta.
module pixel_fetch_pipe
  import pixel_fetch_pipe_pkg::*;
#(
  parameter sram_addr_t MAP_BASE  = MAP_BASE_DEFAULT,
  parameter sram_addr_t CAR1_BASE = CAR1_BASE_DEFAULT,
  parameter sram_addr_t CAR2_BASE = CAR2_BASE_DEFAULT
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_valid,
  input  ObjectID           i_object_id,
  input  sram_addr_t        i_pixel_index,
  input  logic              i_hsync,
  input  logic              i_vsync,
  input  logic              i_vblank,
  pixel_fetch_pipe_if.slave wr_bus,
  output sram_addr_t        o_SRAM_ADDR,
  inout  wire sram_data_t   io_SRAM_DQ,
  output logic              o_SRAM_WE_N,
  output logic              o_SRAM_OE_N,
  output logic              o_SRAM_CE_N,
  output logic              o_SRAM_LB_N,
  output logic              o_SRAM_UB_N,
  output logic [7:0]        o_VGA_R,
  output logic [7:0]        o_VGA_G,
  output logic [7:0]        o_VGA_B,
  output logic              o_VGA_HS,
  output logic              o_VGA_VS,
  output logic              o_rgb_valid
);

  sram_addr_t               base_s;
  sram_addr_t               rd_addr_s;
  sram_addr_t               sram_addr_r;
  logic                     wr_busy_s;
  logic                     wr_claim_s;
  sram_addr_t               wr_claim_addr_s;
  logic                     wr_we_n_s;
  logic                     wr_oe_n_s;
  logic                     wr_dq_oe_s;
  sram_data_t               wr_dq_s;
  logic                     conflict_d1_r;
  logic [FETCH_LATENCY-1:0] valid_sr_r;
  logic [FETCH_LATENCY-1:0] hs_sr_r;
  logic [FETCH_LATENCY-1:0] vs_sr_r;
  rgb888_t                  colour_s;
  rgb888_t                  colour_r;

  sram_write_arbiter u_wr_arb (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_vblank     (i_vblank),
    .i_valid      (i_valid),
    .wr_bus       (wr_bus),
    .o_busy       (wr_busy_s),
    .o_claim      (wr_claim_s),
    .o_claim_addr (wr_claim_addr_s),
    .o_we_n       (wr_we_n_s),
    .o_oe_n       (wr_oe_n_s),
    .o_dq_oe      (wr_dq_oe_s),
    .o_dq         (wr_dq_s)
  );

  // Base address of the selected object; unknown IDs fall back to the map.
  always_comb begin
    base_s = MAP_BASE;
    case (i_object_id)
      OBJECT_MAP:  base_s = MAP_BASE;
      OBJECT_CAR1: base_s = CAR1_BASE;
      OBJECT_CAR2: base_s = CAR2_BASE;
      default:     base_s = MAP_BASE;
    endcase
  end

  // 20-bit sum, deliberately wrapping.
  assign rd_addr_s = base_s + i_pixel_index;

  // Stage 1: address register (write FSM has priority) and conflict flag.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      sram_addr_r   <= 20'd0;
      conflict_d1_r <= 1'b0;
    end else begin
      if (wr_claim_s) begin
        sram_addr_r <= wr_claim_addr_s;
      end else if (i_valid) begin
        sram_addr_r <= rd_addr_s;
      end
      // A pixel requested while a write is in flight cannot be read; black it.
      conflict_d1_r <= i_valid & wr_busy_s;
    end
  end

  // Valid and sync delay lines, matched to the fetch latency.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      valid_sr_r <= {FETCH_LATENCY{1'b0}};
      hs_sr_r    <= {FETCH_LATENCY{1'b1}};
      vs_sr_r    <= {FETCH_LATENCY{1'b1}};
    end else begin
      valid_sr_r <= {valid_sr_r[FETCH_LATENCY-2:0], i_valid};
      hs_sr_r    <= {hs_sr_r[FETCH_LATENCY-2:0], i_hsync};
      vs_sr_r    <= {vs_sr_r[FETCH_LATENCY-2:0], i_vsync};
    end
  end

`ifdef PIXEL_FETCH_BBOX_OVERLAY_EN
  localparam rgb888_t RGB_MAGENTA = '{r: 8'hFF, g: 8'h00, b: 8'hFF};

  logic bbox_s;
  logic bbox_d1_r;

  assign bbox_s = ((i_object_id == OBJECT_CAR1) || (i_object_id == OBJECT_CAR2)) &&
                  is_sprite_edge(i_pixel_index);

  // Border flag travels with the address into the capture stage.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      bbox_d1_r <= 1'b0;
    end else begin
      bbox_d1_r <= bbox_s;
    end
  end
`endif

  // Stage 2 colour selection from the captured SRAM word.
  always_comb begin
    colour_s = RGB_BLACK;
    if (!valid_sr_r[0] || conflict_d1_r) begin
      colour_s = RGB_BLACK;
    end
`ifdef PIXEL_FETCH_BBOX_OVERLAY_EN
    else if (bbox_d1_r) begin
      colour_s = RGB_MAGENTA;
    end
`endif
    else begin
      colour_s = rgb565_expand(io_SRAM_DQ);
    end
  end

  // Stage 2 colour register.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      colour_r <= RGB_BLACK;
    end else begin
      colour_r <= colour_s;
    end
  end

  assign io_SRAM_DQ  = wr_dq_oe_s ? wr_dq_s : 16'bz;
  assign o_SRAM_ADDR = sram_addr_r;
  assign o_SRAM_WE_N = wr_we_n_s;
  assign o_SRAM_OE_N = wr_oe_n_s;
  assign o_SRAM_CE_N = 1'b0;
  assign o_SRAM_LB_N = 1'b0;
  assign o_SRAM_UB_N = 1'b0;
  assign o_VGA_R     = colour_r.r;
  assign o_VGA_G     = colour_r.g;
  assign o_VGA_B     = colour_r.b;
  assign o_VGA_HS    = hs_sr_r[FETCH_LATENCY-1];
  assign o_VGA_VS    = vs_sr_r[FETCH_LATENCY-1];
  assign o_rgb_valid = valid_sr_r[FETCH_LATENCY-1];

endmodule

// File: tb/tb_pixel_fetch_pipe.sv
// Directed bench for pixel_fetch_pipe: table of reads plus hand-written
// sequences for sync alignment, blanking writes, abort, pixel/write collision
// and reset during a write. An asynchronous SRAM model sits on the DQ bus.
module tb_pixel_fetch_pipe;
  import pixel_fetch_pipe_pkg::*;

  logic       clk;
  logic       rst;
  logic       valid;
  ObjectID    object_id;
  sram_addr_t pixel_index;
  logic       hsync;
  logic       vsync;
  logic       vblank;
  sram_addr_t sram_addr;
  wire  [15:0] sram_dq;
  logic       sram_we_n, sram_oe_n, sram_ce_n, sram_lb_n, sram_ub_n;
  logic [7:0] vga_r, vga_g, vga_b;
  logic       vga_hs, vga_vs, rgb_valid;

  pixel_fetch_pipe_if wr_if ();

  pixel_fetch_pipe dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_valid       (valid),
    .i_object_id   (object_id),
    .i_pixel_index (pixel_index),
    .i_hsync       (hsync),
    .i_vsync       (vsync),
    .i_vblank      (vblank),
    .wr_bus        (wr_if),
    .o_SRAM_ADDR   (sram_addr),
    .io_SRAM_DQ    (sram_dq),
    .o_SRAM_WE_N   (sram_we_n),
    .o_SRAM_OE_N   (sram_oe_n),
    .o_SRAM_CE_N   (sram_ce_n),
    .o_SRAM_LB_N   (sram_lb_n),
    .o_SRAM_UB_N   (sram_ub_n),
    .o_VGA_R       (vga_r),
    .o_VGA_G       (vga_g),
    .o_VGA_B       (vga_b),
    .o_VGA_HS      (vga_hs),
    .o_VGA_VS      (vga_vs),
    .o_rgb_valid   (rgb_valid)
  );

  always #5 clk = ~clk;

  // SRAM model: asynchronous read, write sampled while WE_N is low.
  logic [15:0] mem [0:1048575];
  logic        pre_we;
  sram_addr_t  pre_addr;
  sram_data_t  pre_data;

  assign sram_dq = (!sram_oe_n && sram_we_n) ? mem[sram_addr] : 16'bz;

  always @(posedge clk) begin
    if (pre_we) mem[pre_addr] <= pre_data;
    else if (!sram_we_n) mem[sram_addr] <= sram_dq;
  end

  int n_vec = 0;
  int n_mis = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic preload(input sram_addr_t a, input sram_data_t d);
    pre_we = 1'b1; pre_addr = a; pre_data = d;
    @(negedge clk);
    pre_we = 1'b0;
  endtask

  // One-cycle pixel request; address checked after 1 edge, colour after 2.
  task automatic do_read(input string name, input ObjectID id, input sram_addr_t idx,
                         input sram_addr_t exp_addr, input logic [23:0] exp_rgb);
    valid = 1'b1; object_id = id; pixel_index = idx;
    @(negedge clk);
    valid = 1'b0;
    check({name, "_addr"}, 32'(sram_addr), 32'(exp_addr));
    check({name, "_vld_early"}, 32'(rgb_valid), 32'd0);
    @(negedge clk);
    check({name, "_vld"}, 32'(rgb_valid), 32'd1);
    check({name, "_rgb"}, 32'({vga_r, vga_g, vga_b}), 32'(exp_rgb));
  endtask

  typedef struct {
    logic [1:0]  id;
    sram_addr_t  idx;
    sram_data_t  word;
    sram_addr_t  exp_addr;
    logic [23:0] exp_rgb;
  } vec_t;

  vec_t vecs [6];

  initial begin
    logic [7:0] hpat;
    logic [7:0] vpat;
    logic       hs_m1, vs_m1;
    int we_low, acks, ack1, ack2, we_cyc, ack_c;

    vecs[0] = '{2'd0, 20'd1234,    16'hF800, 20'd1234,   24'hFF0000};
    vecs[1] = '{2'd2, 20'd5,       16'h07E0, 20'd308229, 24'h00FF00};
    vecs[2] = '{2'd0, 20'd100,     16'h8410, 20'd100,    24'h848284};
    vecs[3] = '{2'd3, 20'd777,     16'hFFFF, 20'd777,    24'hFFFFFF};
    vecs[4] = '{2'd2, 20'hFFFFF,   16'h1234, 20'd308223, 24'h1045A5};
    vecs[5] = '{2'd1, 20'd33,      16'hAAAA, 20'd307233, 24'hAD5552};

    clk = 1'b0; rst = 1'b1; valid = 1'b0; object_id = OBJECT_MAP; pixel_index = 20'd0;
    hsync = 1'b1; vsync = 1'b1; vblank = 1'b0; pre_we = 1'b0; pre_addr = 20'd0; pre_data = 16'd0;
    wr_if.i_wr_req = 1'b0; wr_if.i_wr_addr = 20'd0; wr_if.i_wr_data = 16'd0;

    // Preload while held in reset.
    for (int i = 0; i < 6; i++) preload(vecs[i].exp_addr, vecs[i].word);
    preload(20'd700, 16'h0000);
    preload(20'd307200, 16'h0000);
    @(negedge clk);

    check("rst_rgb",   32'({vga_r, vga_g, vga_b}), 32'd0);
    check("rst_vld",   32'(rgb_valid), 32'd0);
    check("rst_hs_vs", 32'({vga_hs, vga_vs}), 32'd3);
    check("rst_addr",  32'(sram_addr), 32'd0);
    check("rst_we_oe", 32'({sram_we_n, sram_oe_n}), 32'd2);
    check("rst_ce_lb_ub", 32'({sram_ce_n, sram_lb_n, sram_ub_n}), 32'd0);
    check("rst_ack",   32'(wr_if.o_wr_ack), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Table-driven reads.
    for (int i = 0; i < 6; i++)
      do_read($sformatf("vec%0d", i), ObjectID'(vecs[i].id), vecs[i].idx,
              vecs[i].exp_addr, vecs[i].exp_rgb);

    // Sync alignment with no active pixel and an idle write channel.
    vblank = 1'b1;
    hpat = 8'b1011_0010; vpat = 8'b0110_1101;
    hs_m1 = 1'b1; vs_m1 = 1'b1;
    for (int k = 0; k < 9; k++) begin
      hsync = (k < 8) ? hpat[k] : 1'b1;
      vsync = (k < 8) ? vpat[k] : 1'b1;
      @(negedge clk);
      check($sformatf("sync%0d_hs", k), 32'(vga_hs), 32'(hs_m1));
      check($sformatf("sync%0d_vs", k), 32'(vga_vs), 32'(vs_m1));
      check($sformatf("sync%0d_rgb", k), 32'({rgb_valid, vga_r, vga_g, vga_b}), 32'd0);
      check($sformatf("sync%0d_noack", k), 32'({wr_if.o_wr_ack, sram_we_n}), 32'd1);
      hs_m1 = hsync; vs_m1 = vsync;
    end

    // Two back-to-back blanking writes.
    wr_if.i_wr_req = 1'b1; wr_if.i_wr_addr = 20'd307200; wr_if.i_wr_data = 16'h001F;
    we_low = 0; acks = 0; ack1 = -1; ack2 = -1; we_cyc = -1;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      if (c == 1) begin
        check("wr_setup_oe_n", 32'(sram_oe_n), 32'd1);
        check("wr_setup_addr", 32'(sram_addr), 32'd307200);
      end
      if (!sram_we_n) begin
        we_low++;
        if (we_cyc < 0) we_cyc = c;
      end
      if (wr_if.o_wr_ack) begin
        acks++;
        if (acks == 1) begin
          ack1 = c; wr_if.i_wr_addr = 20'd500; wr_if.i_wr_data = 16'hF81F;
        end else begin
          ack2 = c; wr_if.i_wr_req = 1'b0;
        end
      end
    end
    wr_if.i_wr_req = 1'b0;
    check("wr_we_low_cycles", 32'(we_low), 32'd2);
    check("wr_we_first", 32'(we_cyc), 32'd2);
    check("wr_ack_count", 32'(acks), 32'd2);
    check("wr_ack1_cycle", 32'(ack1), 32'd3);
    check("wr_ack2_cycle", 32'(ack2), 32'd7);
    check("wr_mem0", 32'(mem[307200]), 32'h001F);
    check("wr_mem1", 32'(mem[500]), 32'hF81F);
    check("wr_idle_we_oe", 32'({sram_we_n, sram_oe_n}), 32'd2);

    vblank = 1'b0;
    do_read("car1_after_wr", OBJECT_CAR1, 20'd0, 20'd307200, 24'h0000FF);
    do_read("map_after_wr", OBJECT_MAP, 20'd500, 20'd500, 24'hFF00FF);

    // Abort: blanking ends during SETUP, retry in the next blanking.
    preload(20'd600, 16'h0000);
    vblank = 1'b1;
    wr_if.i_wr_req = 1'b1; wr_if.i_wr_addr = 20'd600; wr_if.i_wr_data = 16'h1111;
    @(negedge clk);
    check("abort_setup_oe_n", 32'(sram_oe_n), 32'd1);
    vblank = 1'b0;
    we_low = 0; acks = 0;
    for (int c = 2; c <= 6; c++) begin
      @(negedge clk);
      if (c == 2) check("abort_oe_n", 32'(sram_oe_n), 32'd0);
      if (!sram_we_n) we_low++;
      if (wr_if.o_wr_ack) acks++;
    end
    check("abort_no_we", 32'(we_low), 32'd0);
    check("abort_no_ack", 32'(acks), 32'd0);
    check("abort_mem_untouched", 32'(mem[600]), 32'h0000);
    vblank = 1'b1;
    ack_c = -1;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (wr_if.o_wr_ack && ack_c < 0) begin
        ack_c = c; wr_if.i_wr_req = 1'b0;
      end
    end
    wr_if.i_wr_req = 1'b0;
    check("retry_ack_cycle", 32'(ack_c), 32'd3);
    check("retry_mem", 32'(mem[600]), 32'h1111);

    // Pixel requested while a write is in flight: write completes, pixel black.
    wr_if.i_wr_req = 1'b1; wr_if.i_wr_addr = 20'd800; wr_if.i_wr_data = 16'h2222;
    @(negedge clk);
    valid = 1'b1; object_id = OBJECT_MAP; pixel_index = 20'd1234;
    @(negedge clk);
    valid = 1'b0;
    check("viol_addr_kept", 32'(sram_addr), 32'd800);
    check("viol_we_n", 32'(sram_we_n), 32'd0);
    @(negedge clk);
    check("viol_vld", 32'(rgb_valid), 32'd1);
    check("viol_black", 32'({vga_r, vga_g, vga_b}), 32'd0);
    check("viol_ack", 32'(wr_if.o_wr_ack), 32'd1);
    wr_if.i_wr_req = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("viol_mem", 32'(mem[800]), 32'h2222);

    // Asynchronous reset during W_STROBE.
    hsync = 1'b0; vsync = 1'b0;
    wr_if.i_wr_req = 1'b1; wr_if.i_wr_addr = 20'd700; wr_if.i_wr_data = 16'h3333;
    @(negedge clk);
    @(negedge clk);
    check("rstw_strobe_we_n", 32'(sram_we_n), 32'd0);
    check("rstw_hs_low", 32'(vga_hs), 32'd0);
    #2 rst = 1'b1;
    #1;
    check("rstw_we_oe", 32'({sram_we_n, sram_oe_n}), 32'd2);
    check("rstw_ack", 32'(wr_if.o_wr_ack), 32'd0);
    check("rstw_addr", 32'(sram_addr), 32'd0);
    check("rstw_hs_vs", 32'({vga_hs, vga_vs}), 32'd3);
    check("rstw_vld_rgb", 32'({rgb_valid, vga_r, vga_g, vga_b}), 32'd0);
    wr_if.i_wr_req = 1'b0; hsync = 1'b1; vsync = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    acks = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (wr_if.o_wr_ack) acks++;
    end
    check("rstw_no_ack", 32'(acks), 32'd0);
    check("rstw_mem_untouched", 32'(mem[700]), 32'h0000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
